// File: rtl/axis_i2c_pkg.sv
// Shared types and constants for the AXI-Stream driven I2C write demonstrator.
package axis_i2c_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_ACK,
        ST_STOP
    } state_e;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } phase_e;

    function automatic logic [BYTE_W-1:0] addr_write_byte(input logic [6:0] addr);
        return {addr, 1'b0};
    endfunction

endpackage

// File: rtl/axis_i2c_top_if.sv
// Board-level signal bundle for axis_i2c_top; SDA is an open-drain net with a pull-up.
interface axis_i2c_top_if;
    logic clk = 1'b0;
    logic arstn;
    wire  i2c_sda;
    logic i2c_scl;

    pullup (i2c_sda);
endinterface

// File: rtl/axis_i2c_master.sv
// I2C write master fed by an AXI-Stream byte sink; SCL/SDA timing from a quarter-period divider.
module axis_i2c_master
    import axis_i2c_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [BYTE_W-1:0] s_tdata_i,
    input  logic              s_tvalid_i,
    output logic              s_tready_o,
    input  logic              s_tlast_i,
    input  logic              sda_i,
    output logic              sda_low_o,
    output logic              scl_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    state_e            state_q;
    phase_e            phase_q;
    logic [CW-1:0]     div_q;
    logic [2:0]        bit_q;
    logic [BYTE_W-1:0] shift_q;
    logic              last_q;
    logic              ack_q;
    logic              flush_q;
    logic              scl_q;
    logic              sda_low_q;

    logic tick;
    logic load_idle;
    logic load_ack;
    logic take_flush;

    assign tick       = (div_q == DIV_LAST);
    assign load_idle  = (state_q == ST_IDLE) && s_tvalid_i && !flush_q;
    assign load_ack   = (state_q == ST_ACK) && (phase_q == Q3) && tick &&
                        ack_q && !last_q && s_tvalid_i;
    // After a NACK the rest of the packet is drained up to tlast without transmission.
    assign take_flush = flush_q && s_tvalid_i;
    assign s_tready_o = load_idle || load_ack || take_flush;

    assign scl_o     = scl_q;
    assign sda_low_o = sda_low_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            phase_q   <= Q0;
            div_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            last_q    <= 1'b0;
            ack_q     <= 1'b0;
            flush_q   <= 1'b0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
        end else begin
            if (take_flush && s_tlast_i) begin
                flush_q <= 1'b0;
            end

            if (state_q == ST_IDLE) begin
                div_q <= '0;
            end else begin
                div_q <= tick ? '0 : div_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (load_idle) begin
                        shift_q   <= s_tdata_i;
                        last_q    <= s_tlast_i;
                        sda_low_q <= 1'b1;
                        phase_q   <= Q0;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (phase_q == Q0) begin
                            phase_q <= Q1;
                        end else begin
                            state_q   <= ST_DATA;
                            phase_q   <= Q0;
                            bit_q     <= 3'd7;
                            scl_q     <= 1'b0;
                            sda_low_q <= ~shift_q[BYTE_W-1];
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        unique case (phase_q)
                            Q0: phase_q <= Q1;
                            Q1: begin
                                phase_q <= Q2;
                                scl_q   <= 1'b1;
                            end
                            Q2: phase_q <= Q3;
                            Q3: begin
                                phase_q <= Q0;
                                scl_q   <= 1'b0;
                                if (bit_q == '0) begin
                                    state_q   <= ST_ACK;
                                    sda_low_q <= 1'b0;
                                end else begin
                                    bit_q     <= bit_q - 1'b1;
                                    shift_q   <= {shift_q[BYTE_W-2:0], 1'b0};
                                    sda_low_q <= ~shift_q[BYTE_W-2];
                                end
                            end
                        endcase
                    end
                end
                ST_ACK: begin
                    if (tick) begin
                        unique case (phase_q)
                            Q0: phase_q <= Q1;
                            Q1: begin
                                phase_q <= Q2;
                                scl_q   <= 1'b1;
                            end
                            Q2: begin
                                phase_q <= Q3;
                                ack_q   <= (sda_i == 1'b0);
                            end
                            Q3: begin
                                phase_q <= Q0;
                                scl_q   <= 1'b0;
                                if (load_ack) begin
                                    state_q   <= ST_DATA;
                                    shift_q   <= s_tdata_i;
                                    last_q    <= s_tlast_i;
                                    bit_q     <= 3'd7;
                                    sda_low_q <= ~s_tdata_i[BYTE_W-1];
                                end else begin
                                    state_q   <= ST_STOP;
                                    sda_low_q <= 1'b1;
                                    if (!ack_q && !last_q) begin
                                        flush_q <= 1'b1;
                                    end
                                end
                            end
                        endcase
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        unique case (phase_q)
                            Q0: begin
                                phase_q <= Q1;
                                scl_q   <= 1'b1;
                            end
                            Q1: begin
                                phase_q   <= Q2;
                                sda_low_q <= 1'b0;
                            end
                            Q2: phase_q <= Q3;
                            Q3: begin
                                phase_q <= Q0;
                                state_q <= ST_IDLE;
                            end
                        endcase
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axis_i2c_top.sv
// Self-contained I2C write demo: a 3-beat AXI-Stream source feeding the I2C master once after reset.
module axis_i2c_top
    import axis_i2c_pkg::*;
#(
    parameter logic [6:0]        SLAVE_ADDR = 7'h50,
    parameter logic [BYTE_W-1:0] DATA0      = 8'hA5,
    parameter logic [BYTE_W-1:0] DATA1      = 8'h3C,
    parameter int unsigned       DIV        = 1
) (
    input  logic clk,
    input  logic arstn,
    inout  wire  i2c_sda,
    output logic i2c_scl
);

    logic [1:0]        idx_q;
    logic              tvalid_q;
    logic              done_q;
    logic [BYTE_W-1:0] tdata;
    logic              tlast;
    logic              tready;
    logic              sda_low;

    always_comb begin
        tdata = DATA1;
        case (idx_q)
            2'd0:    tdata = addr_write_byte(SLAVE_ADDR);
            2'd1:    tdata = DATA0;
            default: tdata = DATA1;
        endcase
    end

    assign tlast = (idx_q == 2'd2);

    // One packet per reset: once the last beat is taken the source goes quiet until the next reset.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            idx_q    <= '0;
            tvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (!done_q) begin
            if (!tvalid_q) begin
                tvalid_q <= 1'b1;
            end else if (tready) begin
                if (tlast) begin
                    tvalid_q <= 1'b0;
                    done_q   <= 1'b1;
                end else begin
                    idx_q <= idx_q + 2'd1;
                end
            end
        end
    end

    axis_i2c_master #(
        .DIV(DIV)
    ) u_master (
        .clk_i     (clk),
        .rst_ni    (arstn),
        .s_tdata_i (tdata),
        .s_tvalid_i(tvalid_q),
        .s_tready_o(tready),
        .s_tlast_i (tlast),
        .sda_i     (i2c_sda),
        .sda_low_o (sda_low),
        .scl_o     (i2c_scl)
    );

    assign i2c_sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_axis_i2c_top.sv
// Bench for axis_i2c_top: two instances (DIV=1, DIV=3) watched by a bus-level I2C decoder and slave model.
module tb_axis_i2c_top;

    localparam logic [6:0] ADDR = 7'h50;
    localparam logic [7:0] D0   = 8'hA5;
    localparam logic [7:0] D1   = 8'h3C;

    axis_i2c_top_if bus ();

    wire        sda1;
    wire        sda3;
    logic       scl3;
    logic [1:0] slave_low = '0;

    pullup (sda1);
    pullup (sda3);
    assign sda1 = slave_low[0] ? 1'b0 : 1'bz;
    assign sda3 = slave_low[1] ? 1'b0 : 1'bz;

    axis_i2c_top #(.SLAVE_ADDR(ADDR), .DATA0(D0), .DATA1(D1), .DIV(1)) dut1 (
        .clk(bus.clk), .arstn(bus.arstn), .i2c_sda(sda1), .i2c_scl(bus.i2c_scl)
    );
    axis_i2c_top #(.SLAVE_ADDR(ADDR), .DATA0(D0), .DATA1(D1), .DIV(3)) dut3 (
        .clk(bus.clk), .arstn(bus.arstn), .i2c_sda(sda3), .i2c_scl(scl3)
    );

    always #5 bus.clk = ~bus.clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int div_of(input int l);
        return (l == 0) ? 1 : 3;
    endfunction

    // Reference: the slave acks the first `acks` bytes; transmission ends at the first NACK or after 3 bytes.
    function automatic int model_nbytes(input int acks);
        return (acks + 1 < 3) ? acks + 1 : 3;
    endfunction

    function automatic int model_byte(input int i);
        case (i)
            0:       return int'({ADDR, 1'b0});
            1:       return int'(D0);
            default: return int'(D1);
        endcase
    endfunction

    function automatic int model_ack(input int i, input int acks);
        return (i < acks) ? 0 : 1;
    endfunction

    function automatic int model_flen(input int n, input int dv);
        return 4 * dv * (9 * n + 1);
    endfunction

    // Bus decoder / slave state, one slot per DUT.
    int       ack_budget [2];
    int       cyc        [2];
    int       lat        [2];
    int       bitcnt     [2];
    int       nbytes     [2];
    int       tstart     [2];
    int       flen       [2];
    int       frames     [2];
    int       nfull      [2];
    int       nshort     [2];
    int       low_len    [2];
    int       high_len   [2];
    bit       in_frame   [2];
    bit       first_high [2];
    bit       lat_done   [2];
    bit       pend       [2];
    bit       pend_bit   [2];
    bit       prev_s     [2];
    bit       prev_d     [2];
    logic [7:0] cur      [2];
    logic [7:0] byte_v   [2][4];
    bit       ack_v      [2][4];

    always @(negedge bus.clk) begin
        bit s, d;
        int dv;
        for (int l = 0; l < 2; l++) begin
            s  = (l == 0) ? bus.i2c_scl : scl3;
            d  = (l == 0) ? sda1 : sda3;
            dv = div_of(l);
            if (!bus.arstn) begin
                chk($sformatf("rst_scl%0d", l), int'(s), 1);
                chk($sformatf("rst_sda%0d", l), int'(d), int'(!slave_low[l]));
                cyc[l] = 0; in_frame[l] = 0; pend[l] = 0; lat_done[l] = 0;
                frames[l] = 0; nbytes[l] = 0; bitcnt[l] = 0; first_high[l] = 0;
                prev_s[l] = 1; prev_d[l] = 1; slave_low[l] = 1'b0;
            end else begin
                cyc[l]++;
                if (prev_s[l] && s && (d != prev_d[l])) begin
                    if (!d) begin
                        chk($sformatf("start_outside_frame%0d", l), int'(in_frame[l]), 0);
                        in_frame[l] = 1; bitcnt[l] = 0; nbytes[l] = 0; tstart[l] = cyc[l];
                        first_high[l] = 1; pend[l] = 0; nfull[l] = 0; nshort[l] = 0;
                    end else begin
                        chk($sformatf("stop_in_frame%0d", l), int'(in_frame[l]), 1);
                        chk($sformatf("stop_on_byte_boundary%0d", l), bitcnt[l] % 9, 0);
                        flen[l] = cyc[l] - tstart[l];
                        frames[l]++;
                        in_frame[l] = 0; pend[l] = 0;
                    end
                end else if (!prev_s[l] && s) begin
                    chk($sformatf("sda_stable_at_rise%0d", l), int'(d), int'(prev_d[l]));
                    if (in_frame[l]) begin
                        if (low_len[l] == 2 * dv) nfull[l]++;
                        else if (low_len[l] == dv) nshort[l]++;
                        else chk($sformatf("scl_low_len%0d", l), low_len[l], 2 * dv);
                    end
                    high_len[l] = 1;
                    pend[l] = in_frame[l];
                    pend_bit[l] = d;
                end else if (prev_s[l] && !s) begin
                    chk($sformatf("scl_fall_in_frame%0d", l), int'(in_frame[l]), 1);
                    if (first_high[l]) begin
                        first_high[l] = 0;
                        if (!lat_done[l]) begin
                            lat[l] = cyc[l];
                            lat_done[l] = 1;
                        end
                    end else begin
                        chk($sformatf("scl_high_len%0d", l), high_len[l], 2 * dv);
                    end
                    if (pend[l]) begin
                        bitcnt[l]++;
                        if (bitcnt[l] % 9 != 0) begin
                            cur[l] = {cur[l][6:0], pend_bit[l]};
                        end else if (nbytes[l] < 4) begin
                            byte_v[l][nbytes[l]] = cur[l];
                            ack_v[l][nbytes[l]] = pend_bit[l];
                            nbytes[l]++;
                        end
                    end
                    pend[l] = 0;
                    low_len[l] = 1;
                    slave_low[l] = in_frame[l] && (bitcnt[l] % 9 == 8) && (nbytes[l] < ack_budget[l]);
                end else begin
                    if (s) high_len[l]++;
                    else low_len[l]++;
                end
                prev_s[l] = s;
                prev_d[l] = d;
            end
        end
    end

    task automatic apply_reset(input int hold);
        @(negedge bus.clk);
        #2 bus.arstn = 1'b0;
        repeat (hold) @(negedge bus.clk);
        #2 bus.arstn = 1'b1;
    endtask

    task automatic wait_frames();
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge bus.clk);
            #1;
            if (frames[0] >= 1 && frames[1] >= 1) begin
                ok = 1;
                break;
            end
        end
        chk("frame_complete_in_budget", int'(ok), 1);
        repeat (60) @(negedge bus.clk);
        #1;
    endtask

    task automatic check_lane(input int l, input int acks);
        int n;
        int dv;
        n  = model_nbytes(acks);
        dv = div_of(l);
        chk($sformatf("frames%0d", l), frames[l], 1);
        chk($sformatf("bus_idle%0d", l), int'(in_frame[l]), 0);
        chk($sformatf("nbytes%0d", l), nbytes[l], n);
        for (int i = 0; i < n && i < 4; i++) begin
            chk($sformatf("byte%0d_lane%0d", i, l), int'(byte_v[l][i]), model_byte(i));
            chk($sformatf("ack%0d_lane%0d", i, l), int'(ack_v[l][i]), model_ack(i, acks));
        end
        chk($sformatf("frame_len%0d", l), flen[l], model_flen(n, dv));
        chk($sformatf("full_low_phases%0d", l), nfull[l], 9 * n);
        chk($sformatf("stop_low_phases%0d", l), nshort[l], 1);
        chk($sformatf("first_fall_latency%0d", l),
            int'(lat[l] >= 2 * dv + 1 && lat[l] <= 2 * dv + 2), 1);
    endtask

    task automatic do_run(input int acks, input int hold);
        ack_budget[0] = acks;
        ack_budget[1] = acks;
        apply_reset(hold);
        wait_frames();
        check_lane(0, acks);
        check_lane(1, acks);
    endtask

    typedef struct {
        int acks;
        int exp_n;
        int exp_last_ack;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int acks;
        int target;
        bit reached;

        bus.arstn = 1'b0;
        ack_budget[0] = 3;
        ack_budget[1] = 3;

        tbl[0] = '{acks: 3, exp_n: 3, exp_last_ack: 0};
        tbl[1] = '{acks: 0, exp_n: 1, exp_last_ack: 1};
        tbl[2] = '{acks: 1, exp_n: 2, exp_last_ack: 1};
        tbl[3] = '{acks: 2, exp_n: 3, exp_last_ack: 1};

        for (int i = 0; i < 4; i++) begin
            do_run(tbl[i].acks, 5);
            for (int l = 0; l < 2; l++) begin
                chk($sformatf("tbl%0d_nbytes%0d", i, l), nbytes[l], tbl[i].exp_n);
                chk($sformatf("tbl%0d_last_ack%0d", i, l),
                    int'(ack_v[l][(nbytes[l] > 0 && nbytes[l] <= 4) ? nbytes[l] - 1 : 0]),
                    tbl[i].exp_last_ack);
            end
        end

        repeat (4) begin
            acks = int'($urandom_range(0, 4));
            do_run(acks, int'($urandom_range(2, 8)));
        end

        // Reset pulse while the DIV=1 instance is inside its second byte.
        ack_budget[0] = 3;
        ack_budget[1] = 3;
        apply_reset(5);
        target  = 10 + int'($urandom_range(0, 5));
        reached = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge bus.clk);
            #1;
            if (in_frame[0] && bitcnt[0] >= target) begin
                reached = 1;
                break;
            end
        end
        chk("midframe_point_reached", int'(reached), 1);
        #2 bus.arstn = 1'b0;
        #1;
        chk("abort_scl1", int'(bus.i2c_scl), 1);
        chk("abort_scl3", int'(scl3), 1);
        chk("abort_sda1", int'(sda1), int'(!slave_low[0]));
        chk("abort_sda3", int'(sda3), int'(!slave_low[1]));
        repeat (3) @(negedge bus.clk);
        #2 bus.arstn = 1'b1;
        wait_frames();
        check_lane(0, 3);
        check_lane(1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
